// File: rtl/vend_pkg.sv
// Shared types and constants for the vending front-end sequencer.
// No timing of its own; the overflow helper is pure combinational.
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CMD,
    S_BUY_CMD,
    S_WAIT_RESP,
    S_SHOW_OK,
    S_SHOW_FAIL
  } state_t;

  localparam logic [1:0] FAIL_NONE     = 2'd0;
  localparam logic [1:0] FAIL_REFUSED  = 2'd1;
  localparam logic [1:0] FAIL_TIMEOUT  = 2'd2;
  localparam logic [1:0] FAIL_OVERFLOW = 2'd3;

  localparam logic [4:0] MAX_BAL = 5'd15;

  // The sum is one bit wider than the 4-bit datapath so a wrap cannot hide an overflow.
  function automatic logic load_overflows(input logic [3:0] bal, input logic [3:0] amt);
    logic [4:0] w_sum;
    w_sum = {1'b0, bal} + {1'b0, amt};
    return (w_sum > MAX_BAL);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: level flips after DEBOUNCE_CYCLES consecutive differing samples; rise is a registered 1-cycle pulse.
// Latency DEBOUNCE_CYCLES cycles from raw change to level/rise; no backpressure, samples every cycle.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] r_cnt;
  logic       r_level;
  logic       r_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (raw != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= raw;
          r_cnt   <= '0;
          r_rise  <= raw;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule

// File: rtl/vend_txn_controller.sv
// Vending front-end: debounced presses become single-cycle load/buy commands, buy verdicts are awaited with a timeout, outcome held for display.
// Load pulse 1 cycle after the press event; presses arriving outside IDLE are dropped rather than queued.
module vend_txn_controller
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RESP_TIMEOUT    = 8,
  parameter int HOLD_CYCLES     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_load,
  input  logic       btn_buy,
  input  logic [3:0] sw_amount,
  input  logic [1:0] sw_sel,
  input  logic [3:0] balance,
  input  logic       dp_yes,
  input  logic       dp_no,
  output logic       load,
  output logic       buy,
  output logic [3:0] b_in,
  output logic [1:0] sel,
  output logic       busy,
  output logic       vend_ok,
  output logic       vend_fail,
  output logic [1:0] fail_code
);

  localparam logic [7:0]  RESP_LAST = 8'(RESP_TIMEOUT - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  logic w_load_level;
  logic w_load_rise;
  logic w_buy_level;
  logic w_buy_rise;
  logic w_load_evt;
  logic w_buy_evt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_load),
    .level (w_load_level),
    .rise  (w_load_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_buy (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_buy),
    .level (w_buy_level),
    .rise  (w_buy_rise)
  );

  assign w_load_evt = w_load_rise & w_load_level;
  assign w_buy_evt  = w_buy_rise & w_buy_level;

  state_t      r_state;
  logic        r_load;
  logic        r_buy;
  logic [3:0]  r_b_in;
  logic [1:0]  r_sel;
  logic        r_busy;
  logic        r_vend_ok;
  logic        r_vend_fail;
  logic [1:0]  r_fail_code;
  logic [7:0]  r_resp;
  logic [15:0] r_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_load      <= 1'b0;
      r_buy       <= 1'b0;
      r_b_in      <= '0;
      r_sel       <= '0;
      r_busy      <= 1'b0;
      r_vend_ok   <= 1'b0;
      r_vend_fail <= 1'b0;
      r_fail_code <= FAIL_NONE;
      r_resp      <= '0;
      r_hold      <= '0;
    end else begin
      r_load <= 1'b0;
      r_buy  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Load has priority; a same-cycle buy event is simply not looked at.
          if (w_load_evt) begin
            if (sw_amount == 4'd0) begin
              r_state <= S_IDLE;
            end else if (load_overflows(balance, sw_amount)) begin
              r_state     <= S_SHOW_FAIL;
              r_busy      <= 1'b1;
              r_vend_fail <= 1'b1;
              r_fail_code <= FAIL_OVERFLOW;
              r_hold      <= '0;
            end else begin
              r_state <= S_LOAD_CMD;
              r_busy  <= 1'b1;
              r_load  <= 1'b1;
              r_b_in  <= sw_amount;
            end
          end else if (w_buy_evt) begin
            r_state <= S_BUY_CMD;
            r_busy  <= 1'b1;
            r_buy   <= 1'b1;
            r_sel   <= sw_sel;
          end
        end
        S_LOAD_CMD: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        S_BUY_CMD: begin
          r_state <= S_WAIT_RESP;
          r_resp  <= '0;
        end
        S_WAIT_RESP: begin
          if (dp_no) begin
            r_state     <= S_SHOW_FAIL;
            r_vend_fail <= 1'b1;
            r_fail_code <= FAIL_REFUSED;
            r_hold      <= '0;
          end else if (dp_yes) begin
            r_state   <= S_SHOW_OK;
            r_vend_ok <= 1'b1;
            r_hold    <= '0;
          end else if (r_resp == RESP_LAST) begin
            r_state     <= S_SHOW_FAIL;
            r_vend_fail <= 1'b1;
            r_fail_code <= FAIL_TIMEOUT;
            r_hold      <= '0;
          end else begin
            r_resp <= r_resp + 8'd1;
          end
        end
        S_SHOW_OK, S_SHOW_FAIL: begin
          if (r_hold == HOLD_LAST) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_vend_ok   <= 1'b0;
            r_vend_fail <= 1'b0;
            r_fail_code <= FAIL_NONE;
          end else begin
            r_hold <= r_hold + 16'd1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_vend_ok   <= 1'b0;
          r_vend_fail <= 1'b0;
          r_fail_code <= FAIL_NONE;
        end
      endcase
    end
  end

  assign load      = r_load;
  assign buy       = r_buy;
  assign b_in      = r_b_in;
  assign sel       = r_sel;
  assign busy      = r_busy;
  assign vend_ok   = r_vend_ok;
  assign vend_fail = r_vend_fail;
  assign fail_code = r_fail_code;

endmodule

// File: tb/tb_vend_txn_controller.sv
// Directed bench for vend_txn_controller: command pulses, latencies, hold lengths and fail codes.
module tb_vend_txn_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_load;
  logic       btn_buy;
  logic [3:0] sw_amount;
  logic [1:0] sw_sel;
  logic [3:0] balance;
  logic       dp_yes;
  logic       dp_no;
  logic       load;
  logic       buy;
  logic [3:0] b_in;
  logic [1:0] sel;
  logic       busy;
  logic       vend_ok;
  logic       vend_fail;
  logic [1:0] fail_code;

  vend_txn_controller dut (
    .clk       (clk),
    .rst       (rst),
    .btn_load  (btn_load),
    .btn_buy   (btn_buy),
    .sw_amount (sw_amount),
    .sw_sel    (sw_sel),
    .balance   (balance),
    .dp_yes    (dp_yes),
    .dp_no     (dp_no),
    .load      (load),
    .buy       (buy),
    .b_in      (b_in),
    .sel       (sel),
    .busy      (busy),
    .vend_ok   (vend_ok),
    .vend_fail (vend_fail),
    .fail_code (fail_code)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Monitor state, sampled 1 time unit after each rising edge.
  int cyc = 0;
  int n_load, n_buy, n_ok, n_fail, n_both, n_back;
  int load_cyc, buy_cyc, ok_start, fail_start;
  logic [3:0] load_bin;
  logic [1:0] buy_sel;
  logic [1:0] code_first;
  logic prev_cmd = 1'b0;
  logic prev_ok = 1'b0;
  logic prev_fail = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (load) begin n_load++; load_cyc = cyc; load_bin = b_in; end
    if (buy) begin n_buy++; buy_cyc = cyc; buy_sel = sel; end
    if (vend_ok) begin n_ok++; if (!prev_ok) ok_start = cyc; end
    if (vend_fail) begin
      n_fail++;
      if (!prev_fail) begin fail_start = cyc; code_first = fail_code; end
    end
    if (load && buy) n_both++;
    if ((load || buy) && prev_cmd) n_back++;
    prev_cmd  = load || buy;
    prev_ok   = vend_ok;
    prev_fail = vend_fail;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    n_load = 0; n_buy = 0; n_ok = 0; n_fail = 0;
    load_cyc = -1; buy_cyc = -1; ok_start = -1; fail_start = -1;
    load_bin = '0; buy_sel = '0; code_first = '0;
  endtask

  // Wait (bounded) for a buy pulse; leaves the caller on the negedge of the pulse cycle.
  task automatic wait_buy(input string tag);
    for (int i = 0; i < 20 && !buy; i++) @(negedge clk);
    chk(tag, {31'd0, buy}, 32'd1);
  endtask

  int press;

  initial begin
    rst = 1'b1; btn_load = 1'b0; btn_buy = 1'b0;
    sw_amount = '0; sw_sel = '0; balance = '0; dp_yes = 1'b0; dp_no = 1'b0;
    n_both = 0; n_back = 0;
    clear_counts();

    // Reset state
    cycles(3);
    chk("reset_outputs", {20'd0, load, buy, b_in, sel, busy, vend_ok, vend_fail, fail_code}, 32'd0);
    rst = 1'b0;
    cycles(1);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);

    // 2-cycle glitch on load gives nothing
    sw_amount = 4'd5; balance = 4'd3;
    btn_load = 1'b1; cycles(2); btn_load = 1'b0;
    cycles(10);
    chk("glitch_no_load", n_load, 0);

    // Clean load: pulse DEBOUNCE_CYCLES+1 after press
    press = cyc; btn_load = 1'b1; cycles(6); btn_load = 1'b0;
    cycles(10);
    chk("load_count", n_load, 1);
    chk("load_latency", load_cyc - press, 5);
    chk("load_b_in", {28'd0, load_bin}, 32'd5);
    chk("b_in_held", {28'd0, b_in}, 32'd5);
    chk("load_idle_after", {31'd0, busy}, 32'd0);

    // Zero amount is ignored
    clear_counts();
    sw_amount = 4'd0;
    btn_load = 1'b1; cycles(6); btn_load = 1'b0; cycles(10);
    chk("zero_amt_no_load", n_load + n_fail, 0);

    // Exact fit to MAX_BAL is accepted
    sw_amount = 4'd4; balance = 4'd11;
    btn_load = 1'b1; cycles(6); btn_load = 1'b0; cycles(10);
    chk("fit15_load", n_load, 1);
    chk("fit15_b_in", {28'd0, b_in}, 32'd4);

    // Overflow 12+4
    clear_counts();
    balance = 4'd12; sw_amount = 4'd4;
    press = cyc; btn_load = 1'b1; cycles(6); btn_load = 1'b0;
    cycles(30);
    chk("ovf_no_load", n_load, 0);
    chk("ovf_start", fail_start - press, 5);
    chk("ovf_code", {30'd0, code_first}, 32'd3);
    chk("ovf_hold_len", n_fail, 16);
    chk("ovf_cleared", {28'd0, busy, vend_fail, fail_code}, 32'd0);

    // Buy success, dp_yes 2 cycles after buy pulse
    clear_counts();
    balance = 4'd9; sw_sel = 2'd2;
    btn_buy = 1'b1;
    wait_buy("ok_buy_seen");
    btn_buy = 1'b0;
    cycles(2); dp_yes = 1'b1; cycles(1); dp_yes = 1'b0;
    cycles(25);
    chk("ok_buy_count", n_buy, 1);
    chk("ok_sel", {30'd0, buy_sel}, 32'd2);
    chk("ok_start", ok_start - buy_cyc, 3);
    chk("ok_hold_len", n_ok, 16);
    chk("ok_no_fail", n_fail, 0);
    chk("ok_busy_after", {31'd0, busy}, 32'd0);

    // Buy timeout; a second buy press during the hold is ignored
    clear_counts();
    sw_sel = 2'd1;
    btn_buy = 1'b1;
    wait_buy("to_buy_seen");
    btn_buy = 1'b0;
    cycles(10);
    btn_buy = 1'b1; cycles(6); btn_buy = 1'b0;
    cycles(30);
    chk("to_start", fail_start - buy_cyc, 9);
    chk("to_code", {30'd0, code_first}, 32'd2);
    chk("to_hold_len", n_fail, 16);
    chk("to_press_ignored", n_buy, 1);
    chk("to_busy_after", {31'd0, busy}, 32'd0);

    // Both dp_yes and dp_no -> refused
    clear_counts();
    sw_sel = 2'd3;
    btn_buy = 1'b1;
    wait_buy("ref_buy_seen");
    btn_buy = 1'b0;
    cycles(1); dp_yes = 1'b1; dp_no = 1'b1; cycles(1); dp_yes = 1'b0; dp_no = 1'b0;
    cycles(25);
    chk("ref_start", fail_start - buy_cyc, 2);
    chk("ref_code", {30'd0, code_first}, 32'd1);
    chk("ref_no_ok", n_ok, 0);

    // Simultaneous load and buy: load wins
    clear_counts();
    balance = 4'd0; sw_amount = 4'd7;
    btn_load = 1'b1; btn_buy = 1'b1; cycles(6); btn_load = 1'b0; btn_buy = 1'b0;
    cycles(20);
    chk("sim_load", n_load, 1);
    chk("sim_no_buy", n_buy, 0);
    chk("sim_b_in", {28'd0, b_in}, 32'd7);

    // Reset in the middle of WAIT_RESP
    clear_counts();
    sw_sel = 2'd2;
    btn_buy = 1'b1;
    wait_buy("rst_buy_seen");
    btn_buy = 1'b0;
    cycles(2);
    rst = 1'b1; cycles(1); rst = 1'b0;
    chk("rst_mid_outputs", {20'd0, load, buy, b_in, sel, busy, vend_ok, vend_fail, fail_code}, 32'd0);
    cycles(30);
    chk("rst_mid_no_more_buy", n_buy, 1);
    chk("rst_mid_no_status", n_ok + n_fail, 0);

    // Global command invariants
    chk("never_load_and_buy", n_both, 0);
    chk("never_back_to_back", n_back, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vend_txn_controller.md
Name: vend_txn_controller

Overview:
Front-end sequencer for the vending datapath. It debounces the raw load and buy buttons and turns each accepted press into exactly one single-cycle load or buy command. Each command carries a latched amount or product select. For a buy, it waits for the datapath's yes/no verdict, bounded by a timeout, then holds the outcome for a fixed display time. It sits between the board buttons/switches and the balance/vend datapath; its status outputs feed the display path.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable samples needed before a button level is accepted (1..255)
RESP_TIMEOUT, 8, max cycles spent in WAIT_RESP before declaring a timeout (1..255)
HOLD_CYCLES, 16, cycles the OK/FAIL status is held before returning to IDLE (1..65535)
MAX_BAL, 15, highest balance the 4-bit datapath can hold

Ports:
clk  input  1  system clock; the only clock
rst  input  1  synchronous, active-high reset
btn_load  input  1  raw load button, level, already synchronised to clk
btn_buy  input  1  raw buy button, level, already synchronised to clk
sw_amount  input  4  coin amount switches
sw_sel  input  2  product select switches
balance  input  4  current balance reported by the datapath
dp_yes  input  1  datapath: vend succeeded
dp_no  input  1  datapath: vend refused
load  output  1  one-cycle load command to the datapath
buy  output  1  one-cycle buy command to the datapath
b_in  output  4  latched amount; stable from the load pulse until the next accepted load
sel  output  2  latched select; stable from the buy pulse until the next accepted buy
busy  output  1  high in every state except IDLE
vend_ok  output  1  high throughout SHOW_OK
vend_fail  output  1  high throughout SHOW_FAIL
fail_code  output  2  0 none, 1 refused, 2 timeout, 3 overflow; valid while vend_fail=1

Behaviour:
- Reset: all outputs 0, FSM in IDLE, debounce counters cleared, debounced levels 0. Reset takes effect mid-operation from any state, and the next cycle behaves as post-reset. No command may issue in the cycle reset is released.
- Debounce, per button:
  - a counter resets whenever the raw level differs from the accepted level;
  - after DEBOUNCE_CYCLES consecutive differing samples, the accepted level flips;
  - a press event is the accepted level's rising edge (1 cycle).
- Press events are registered. Events arriving outside IDLE are discarded, not queued.
- FSM states: IDLE, LOAD_CMD, BUY_CMD, WAIT_RESP, SHOW_OK, SHOW_FAIL.
- IDLE, load event present:
  - sw_amount==0: event ignored, stay in IDLE.
  - balance+sw_amount > MAX_BAL (sum computed 5 bits wide): go to SHOW_FAIL with fail_code=3, and no load pulse.
  - otherwise: latch b_in=sw_amount and go to LOAD_CMD.
- IDLE, buy event only: latch sel=sw_sel and go to BUY_CMD.
- IDLE, load and buy events in the same cycle: load wins; the buy event is dropped.
- LOAD_CMD: load=1 for this single cycle, then IDLE. Total latency from press event to load pulse = 1 cycle.
- BUY_CMD: buy=1 for this single cycle, then WAIT_RESP with the response counter cleared.
- WAIT_RESP: sample dp_yes/dp_no each cycle, starting the cycle after the buy pulse.
  - dp_yes only: SHOW_OK.
  - dp_no only: SHOW_FAIL, fail_code=1.
  - both asserted: treated as refused, fail_code=1.
  - neither after RESP_TIMEOUT cycles: SHOW_FAIL, fail_code=2.
- SHOW_OK / SHOW_FAIL: hold the status for exactly HOLD_CYCLES cycles, then IDLE with vend_ok, vend_fail and fail_code cleared.
- dp_yes/dp_no outside WAIT_RESP are ignored.
- load and buy are never high together and never high for 2 consecutive cycles.

Decomposition:
- Shared package vend_pkg holds:
  - the FSM state enum (state_t);
  - the fail_code encodings FAIL_NONE, FAIL_REFUSED, FAIL_TIMEOUT, FAIL_OVERFLOW;
  - the MAX_BAL constant.
- One sub-module, btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, raw, level, rise), is instantiated twice.
- Counters and the FSM live in vend_txn_controller.

Test Plan:
- Reset mid-WAIT_RESP: assert rst for 1 cycle -> next cycle busy=0 and all outputs 0; no buy pulse and no status follow.
- Load, sw_amount=5, balance=3, btn_load held 6 cycles -> exactly one load pulse, DEBOUNCE_CYCLES+1 cycles after the press, with b_in=5; a 2-cycle glitch produces no pulse.
- Load overflow, balance=12, sw_amount=4 -> no load pulse; vend_fail=1, fail_code=3 for 16 cycles; then IDLE.
- Buy success, sw_sel=2, dp_yes driven 2 cycles after the buy pulse -> one buy pulse with sel=2; vend_ok high exactly 16 cycles; busy low afterwards.
- Buy timeout with dp_yes/dp_no held 0 -> vend_fail=1, fail_code=2 entered 8 cycles after the buy pulse; a buy press during the hold is ignored.
- Simultaneous debounced load and buy rising edges -> load pulse only, and no buy pulse ever follows from that press.
